cipher_uart_tx: RTL and testbench
=================================

CIPHER_UART_TX -- requirements
Module: cipher_uart_tx

Interface
REQ-001 Parameter N, default 8: cipher byte width, equal to bits per UART frame.
REQ-002 Parameter CLKS_PER_BIT, default 434: clk cycles per UART bit; legal values >= 2.
REQ-003 Parameter FIFO_DEPTH, default 4: entries in the input buffer; power of two, >= 2.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: asynchronous, active-low reset.
REQ-006 send_to_uart  input  1: one-cycle strobe from the scrambler meaning cipher_text is valid this cycle.
REQ-007 cipher_text  input  N: scrambled byte to transmit, sampled only when send_to_uart=1.
REQ-008 tx  output  1: registered UART serial line, idle high.
REQ-009 busy  output  1: high while a frame is in progress (state != IDLE).
REQ-010 fifo_full  output  1: high when the buffer holds FIFO_DEPTH entries.
REQ-011 overflow  output  1: sticky flag, set when a byte is dropped.
REQ-012 tx_done  output  1: one-cycle pulse at the end of each stop bit.

Function
REQ-013 The buffer SHALL push cipher_text on an edge where send_to_uart=1 and either count < FIFO_DEPTH or a pop occurs on the same edge.
REQ-014 A strobe arriving while full with no pop on that edge SHALL drop the byte, leave the contents unchanged and set overflow=1 until reset.
REQ-015 The buffer SHALL be FIFO-ordered, with read and write pointers wrapping modulo FIFO_DEPTH and a count of width clog2(FIFO_DEPTH)+1.
REQ-016 The FSM states SHALL be IDLE, START, DATA and STOP; a baud counter of width clog2(CLKS_PER_BIT) and a bit index of width clog2(N) are required.
REQ-017 IDLE: tx=1; on an edge with count>0, pop the head into the shift register, clear the baud counter, drive tx=0 and go to START.
REQ-018 START: hold tx=0 for CLKS_PER_BIT cycles, then drive bit 0 and go to DATA with bit index 0.
REQ-019 DATA: send N bits LSB first, CLKS_PER_BIT cycles each; after bit N-1, drive tx=1 and go to STOP.
REQ-020 STOP: hold tx=1 for CLKS_PER_BIT cycles; on the final edge, pulse tx_done=1 for one cycle and return to IDLE.
REQ-021 Latency: a byte pushed at edge k into an empty buffer with the FSM in IDLE SHALL drive tx low at edge k+1.
REQ-022 A frame SHALL last exactly (N+2)*CLKS_PER_BIT cycles.
REQ-023 Back-to-back frames SHALL be separated by exactly one IDLE cycle with tx=1.
REQ-024 A push and a pop on the same edge SHALL leave count unchanged.
REQ-025 A push on the pop edge while full SHALL be accepted and SHALL NOT set overflow.
REQ-026 Baud counter and bit index SHALL reset to 0 on every state transition; there SHALL be no partial bits.

Reset
REQ-027 While rst=0, the block SHALL hold tx=1, busy=0, fifo_full=0, overflow=0, tx_done=0, count=0, both pointers=0 and state=IDLE, asynchronously.
REQ-028 Reset asserted mid-frame SHALL abort the frame, return tx high immediately and discard all buffered bytes.
REQ-029 Strobes during reset SHALL be ignored; the first push is possible on the first rising edge after rst deasserts.

Verification (CLKS_PER_BIT=4, N=8, FIFO_DEPTH=4)
REQ-030 Single 0xA5 strobe at edge k -> tx goes low at k+1 and emits 0,1,0,1,0,0,1,0,1,1 for 4 cycles each; tx_done pulses once 40 cycles after k+1; busy is high for those 40 cycles.
REQ-031 Six consecutive strobes 0x01..0x06 from idle -> 0x01..0x05 are transmitted in order, 0x06 is dropped, overflow=1 and fifo_full=1 after the 6th edge.
REQ-032 Two queued bytes 0x00 and 0xFF -> tx stays high for exactly one cycle between the stop bit of frame 1 and the start bit of frame 2.
REQ-033 Buffer full and a strobe 0x77 on the edge the FSM pops -> 0x77 is accepted as the last entry, overflow stays 0 and count stays 4.
REQ-034 rst=0 during DATA bit 3 of 0x3C with 2 bytes queued -> tx=1 and busy=0 at once; after release no frame starts until a new strobe arrives.
REQ-035 Overflow set, then further strobes accepted after the buffer drains -> overflow stays 1 until rst=0.

Source files
------------

// File: rtl/cipher_uart_tx_if.sv
// ---------------------------------------------------------------------------
// cipher_uart_tx_if
// Groups the byte-in handshake and the UART-side status signals that run
// between the scrambler and the cipher UART transmitter.
//
//   send_to_uart : one-cycle strobe, cipher_text valid this cycle
//   cipher_text  : scrambled byte (N bits)
//   tx           : UART serial line, idle high
//   busy         : frame in progress
//   fifo_full    : input buffer holds FIFO_DEPTH entries
//   overflow     : sticky, a byte was dropped
//   tx_done      : one-cycle pulse at the end of each stop bit
//
// master = scrambler side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface cipher_uart_tx_if #(
    parameter int N = 8
);
    logic         send_to_uart;
    logic [N-1:0] cipher_text;
    logic         tx;
    logic         busy;
    logic         fifo_full;
    logic         overflow;
    logic         tx_done;

    modport master (
        output send_to_uart,
        output cipher_text,
        input  tx,
        input  busy,
        input  fifo_full,
        input  overflow,
        input  tx_done
    );

    modport slave (
        input  send_to_uart,
        input  cipher_text,
        output tx,
        output busy,
        output fifo_full,
        output overflow,
        output tx_done
    );
endinterface

// File: rtl/cipher_uart_tx.sv
// ---------------------------------------------------------------------------
// cipher_uart_tx
// Buffers scrambled bytes in a small FIFO and serialises them as 8N1-style
// UART frames (start bit, N data bits LSB first, one stop bit).
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : cipher_uart_tx_if.slave (strobe/byte in, tx line and status out)
//
// FSM states:
//   state | meaning
//   IDLE  | line high, waiting for a buffered byte
//   START | start bit (tx=0) for CLKS_PER_BIT cycles
//   DATA  | N data bits, LSB first, CLKS_PER_BIT cycles each
//   STOP  | stop bit (tx=1); tx_done pulses as the FSM leaves
// ---------------------------------------------------------------------------
module cipher_uart_tx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    cipher_uart_tx_if.slave   bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(N);

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [IW-1:0] r_bit_idx;
    logic [N-1:0]  r_shift;
    logic          r_tx;
    logic          r_tx_done;

    logic [N-1:0]  r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_pop;
    logic          w_push;
    logic [N-1:0]  w_head;

    // The FSM only pops from IDLE; a pop frees a slot on the same edge, so a
    // strobe arriving while full is still accepted on the pop edge.
    assign w_pop  = (r_state == IDLE) && (r_count != '0);
    assign w_push = bus.send_to_uart && ((r_count != DEPTH_C) || w_pop);
    assign w_head = r_mem[r_rd_ptr];

    // Storage carries no reset: contents are only meaningful under r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.cipher_text;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.send_to_uart && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx      <= 1'b1;
                    r_baud    <= '0;
                    r_bit_idx <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit_idx == BIT_LAST) begin
                            r_bit_idx <= '0;
                            r_tx      <= 1'b1;
                            r_state   <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud    <= '0;
                        r_tx_done <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud    <= '0;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx        = r_tx;
    assign bus.busy      = (r_state != IDLE);
    assign bus.fifo_full = (r_count == DEPTH_C);
    assign bus.overflow  = r_overflow;
    assign bus.tx_done   = r_tx_done;

endmodule

// File: tb/tb_cipher_uart_tx.sv
module tb_cipher_uart_tx;
    localparam int N     = 8;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = (N + 2) * CPB;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    cipher_uart_tx_if #(.N(N)) bus ();

    cipher_uart_tx #(
        .N(N),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: frame timing from arithmetic on the frame start cycle
    int         t;
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    bit         m_act;
    int         m_start;
    logic [7:0] m_byte;
    bit         m_ovf;
    bit         m_done;

    // independent line receiver
    bit         rx_act;
    int         rx_t;
    logic [7:0] rx_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic exp_tx();
        int b;
        if (!m_act) return 1'b1;
        b = (t - m_start) / CPB;
        if (b == 0) return 1'b0;
        if (b <= N) return m_byte[b-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_sent.delete();
        m_act  = 0;
        m_ovf  = 0;
        m_done = 0;
        rx_act = 0;
        rx_t   = 0;
    endtask

    task automatic model_edge(input logic s, input logic [7:0] d);
        m_done = 0;
        if (m_act) begin
            if (t - m_start == FRAME) begin
                m_act  = 0;
                m_done = 1;
            end
        end else if (m_q.size() > 0) begin
            m_byte = m_q.pop_front();
            m_sent.push_back(m_byte);
            m_act   = 1;
            m_start = t;
        end
        if (s) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1;
        end
    endtask

    task automatic rx_sample();
        logic [7:0] want;
        if (!rx_act) begin
            if (bus.tx === 1'b0) begin
                rx_act = 1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2 && rx_t / CPB >= 1 && rx_t / CPB <= N)
                rx_byte[rx_t / CPB - 1] = bus.tx;
            if (rx_t == (N + 1) * CPB + CPB / 2) begin
                chk("rx_stop_bit", 32'(bus.tx), 32'd1);
                want = (m_sent.size() > 0) ? m_sent.pop_front() : 8'hxx;
                chk("rx_byte", 32'(rx_byte), 32'(want));
            end
            if (rx_t == FRAME - 1) rx_act = 0;
        end
    endtask

    task automatic step(input logic s, input logic [7:0] d);
        bus.send_to_uart = s;
        bus.cipher_text  = d;
        @(posedge clk);
        t++;
        model_edge(s, d);
        #1;
        chk("tx",        32'(bus.tx),        32'(exp_tx()));
        chk("busy",      32'(bus.busy),      32'(m_act));
        chk("fifo_full", 32'(bus.fifo_full), 32'(m_q.size() == DEPTH));
        chk("overflow",  32'(bus.overflow),  32'(m_ovf));
        chk("tx_done",   32'(bus.tx_done),   32'(m_done));
        rx_sample();
        bus.send_to_uart = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx"},       32'(bus.tx),        32'd1);
        chk({tag, "_busy"},     32'(bus.busy),      32'd0);
        chk({tag, "_full"},     32'(bus.fifo_full), 32'd0);
        chk({tag, "_overflow"}, 32'(bus.overflow),  32'd0);
        chk({tag, "_done"},     32'(bus.tx_done),   32'd0);
    endtask

    // called #1 after an edge; checks the asynchronous effect before any edge
    task automatic apply_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rst_async");
        bus.send_to_uart = 1'b1;
        bus.cipher_text  = 8'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        bus.send_to_uart = 1'b0;
        rst = 1'b1;
    endtask

    logic [9:0] a5_bits;
    int         busy_n, done_n, done_at, gap, seen_rise, seen_fall;
    logic       tr_tx  [48];
    logic       tr_busy[48];
    logic       tr_done[48];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        t     = 0;
        rst   = 1'b0;
        bus.send_to_uart = 1'b0;
        bus.cipher_text  = '0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // single 0xA5 frame, explicit waveform
        step(1'b1, 8'hA5);
        for (int i = 0; i < 48; i++) begin
            step(1'b0, 8'h00);
            tr_tx[i]   = bus.tx;
            tr_busy[i] = bus.busy;
            tr_done[i] = bus.tx_done;
        end
        a5_bits = 10'b11_0100_1010;
        for (int i = 0; i < FRAME; i++)
            chk("a5_wave", 32'(tr_tx[i]), 32'(a5_bits[i / CPB]));
        busy_n = 0; done_n = 0; done_at = -1;
        for (int i = 0; i < 48; i++) begin
            if (tr_busy[i]) busy_n++;
            if (tr_done[i]) begin done_n++; done_at = i; end
        end
        chk("a5_busy_cycles", 32'(busy_n), 32'(FRAME));
        chk("a5_done_count", 32'(done_n), 32'd1);
        chk("a5_done_at", 32'(done_at), 32'(FRAME));

        // six strobes 0x01..0x06: last one dropped
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
        chk("six_overflow", 32'(bus.overflow), 32'd1);
        chk("six_full", 32'(bus.fifo_full), 32'd1);
        idle(5 * (FRAME + 1) + 5);
        // overflow stays set after drain and new accepted bytes
        step(1'b1, 8'h5A);
        step(1'b1, 8'hC3);
        idle(2 * (FRAME + 1) + 5);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        chk("drained_sent", 32'(m_sent.size()), 32'd0);

        // 0x00 then 0xFF: exactly one idle cycle between frames
        apply_reset();
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        gap = 0; seen_rise = 0; seen_fall = 0;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            step(1'b0, 8'h00);
            if (bus.busy) begin
                if (seen_fall) seen_rise = 1;
            end else if (i > 0 && !seen_rise) begin
                seen_fall = 1;
                gap++;
            end
        end
        chk("b2b_gap", 32'(gap), 32'd1);

        // strobe on the pop edge while full is accepted
        apply_reset();
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        step(1'b1, 8'h44);
        step(1'b1, 8'h55);
        chk("pre_pop_full", 32'(bus.fifo_full), 32'd1);
        for (int i = 0; i < FRAME + 4 && !m_done; i++) step(1'b0, 8'h00);
        chk("pop_edge_found", 32'(m_done), 32'd1);
        step(1'b1, 8'h77);
        chk("pop_push_overflow", 32'(bus.overflow), 32'd0);
        chk("pop_push_full", 32'(bus.fifo_full), 32'd1);
        idle(5 * (FRAME + 1) + 5);

        // reset during DATA bit 3 of 0x3C with two bytes queued
        apply_reset();
        step(1'b1, 8'h3C);
        step(1'b1, 8'hAA);
        step(1'b1, 8'hBB);
        idle(4 * CPB);
        chk("mid_frame_busy", 32'(bus.busy), 32'd1);
        apply_reset();
        idle(2 * FRAME);
        chk("post_abort_sent", 32'(m_sent.size()), 32'd0);

        // randomized traffic
        apply_reset();
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 300; i++) begin
                logic s;
                s = ($urandom_range(99) < (ph == 0 ? 5 : (ph == 1 ? 20 : 60)));
                step(s, 8'($urandom));
            end
        end
        idle(6 * (FRAME + 1));
        chk("rand_drained", 32'(m_sent.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
